// File: rtl/led_arbiter_if.sv
// Bundle between the sensor display requesters and the LED arbiter.
// The master side drives requests and patterns; the slave side is the arbiter.
interface led_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [6*NUM_REQ-1:0] pattern;
   logic [NUM_REQ-1:0]   grant;
   logic                 active;
   logic [5:0]           led;

   modport master (output req, output pattern, input grant, input active, input led);
   modport slave  (input req, input pattern, output grant, output active, output led);
endinterface

// File: rtl/led_arbiter.sv
// Time-slicing round-robin arbiter for the board's six active-low LEDs,
// falling back to a rotating one-hot walk when nobody is requesting.
module led_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int SLICE_CYCLES = 13500000,
   parameter int STEP_CYCLES  = 13500000,
   parameter int CNT_W        = 24
) (
   input logic          clk,
   input logic          rst_n,
   led_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(SLICE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   timer, timer_nxt;
   logic [5:0]         walk, walk_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]   winner, winner_nxt;
   logic [NUM_REQ-1:0] grant_q, grant_nxt;
   logic               active_q, active_nxt;
   logic [5:0]         led_q, led_nxt;
   logic [IDX_W-1:0]   next_ptr;
   logic [IDX_W:0]     pick_cur, pick_next;

   // Returns {found, index} of the first asserted request searching upward from ptr.
   function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] r,
                                           input logic [IDX_W-1:0] ptr);
      logic [IDX_W:0] res;
      int k;
      res = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = (int'(ptr) + i) % NUM_REQ;
         if (r[k]) res = {1'b1, IDX_W'(k)};
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         timer    <= '0;
         walk     <= 6'b000001;
         rr_ptr   <= '0;
         winner   <= '0;
         grant_q  <= '0;
         active_q <= 1'b0;
         led_q    <= 6'b111110;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         walk     <= walk_nxt;
         rr_ptr   <= rr_ptr_nxt;
         winner   <= winner_nxt;
         grant_q  <= grant_nxt;
         active_q <= active_nxt;
         led_q    <= led_nxt;
      end
   end

   // The arbitration pointer after a release always starts just past the current winner.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      walk_nxt   = walk;
      rr_ptr_nxt = rr_ptr;
      winner_nxt = winner;
      grant_nxt  = grant_q;
      active_nxt = active_q;
      led_nxt    = led_q;
      next_ptr   = (winner == LAST_IDX) ? '0 : winner + 1'b1;
      pick_cur   = pick(bus.req, rr_ptr);
      pick_next  = pick(bus.req, next_ptr);

      case (state)
         IDLE: begin
            if (pick_cur[IDX_W]) begin
               state_nxt  = GRANT;
               winner_nxt = pick_cur[IDX_W-1:0];
               grant_nxt  = NUM_REQ'(1) << pick_cur[IDX_W-1:0];
               active_nxt = 1'b1;
               timer_nxt  = '0;
               led_nxt    = ~bus.pattern[6*int'(pick_cur[IDX_W-1:0]) +: 6];
            end else begin
               if (timer == STEP_LAST) begin
                  walk_nxt  = {walk[4:0], walk[5]};
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
               led_nxt = ~walk_nxt;
            end
         end
         GRANT: begin
            if (bus.req[winner] && (timer < SLICE_LAST)) begin
               timer_nxt = timer + 1'b1;
               led_nxt   = ~bus.pattern[6*int'(winner) +: 6];
            end else begin
               rr_ptr_nxt = next_ptr;
               timer_nxt  = '0;
               if (pick_next[IDX_W]) begin
                  winner_nxt = pick_next[IDX_W-1:0];
                  grant_nxt  = NUM_REQ'(1) << pick_next[IDX_W-1:0];
                  active_nxt = 1'b1;
                  led_nxt    = ~bus.pattern[6*int'(pick_next[IDX_W-1:0]) +: 6];
               end else begin
                  state_nxt  = IDLE;
                  grant_nxt  = '0;
                  active_nxt = 1'b0;
                  led_nxt    = ~walk;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.grant  = grant_q;
   assign bus.active = active_q;
   assign bus.led    = led_q;
endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: stimulus pushes expected outputs per edge,
// a separate monitor pops and compares them after each edge.
module tb_led_arbiter;
   logic clk;
   logic rst_n;

   led_arbiter_if #(.NUM_REQ(4)) bus ();

   led_arbiter #(
      .NUM_REQ(4),
      .SLICE_CYCLES(8),
      .STEP_CYCLES(4),
      .CNT_W(24)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic       chk;
      logic [3:0] g;
      logic       a;
      logic [5:0] l;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Patterns p3..p0; the granted requester shows the inverse on led.
   localparam logic [5:0] P0 = 6'b101010;
   localparam logic [5:0] P1 = 6'b110011;
   localparam logic [5:0] P2 = 6'b001111;
   localparam logic [5:0] P3 = 6'b100001;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic chk,
                                input logic [3:0] g, input logic a, input logic [5:0] l,
                                input string name);
      exp_t e;
      rst_n   = rst;
      bus.req = r;
      e.chk = chk; e.g = g; e.a = a; e.l = l; e.name = name;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input exp_t e);
      total++;
      if (bus.grant !== e.g || bus.active !== e.a || bus.led !== e.l) begin
         bad++;
         $display("[TB] FAIL %s: grant/active/led got %b/%b/%b expected %b/%b/%b",
                  e.name, bus.grant, bus.active, bus.led, e.g, e.a, e.l);
      end
   endtask

   // Monitor: one expectation per clock edge, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) checkOutput(e);
         end
      end
   end

   initial begin
      logic [5:0] w;
      logic [3:0] rr_g [6];
      logic [5:0] rr_l [6];
      rr_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      rr_l = '{~P0, ~P1, ~P3, ~P0, ~P1, ~P3};

      rst_n = 1'b0;
      bus.req = 4'b0000;
      bus.pattern = {P3, P2, P1, P0};

      $display("[TB] reset and idle walk");
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b111110, "reset_a");
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b111110, "reset_b");
      for (int k = 1; k <= 32; k++) begin
         w = 6'b000001 << ((k / 4) % 6);
         applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, ~w, "idle_walk");
      end

      $display("[TB] early release to idle from walk 000100");
      for (int k = 0; k < 3; k++)
         applyStimulus(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, ~P2, "grant_req2");
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b111011, "release_idle");
      for (int k = 1; k <= 3; k++)
         applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b111011, "walk_resume_hold");
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b110111, "walk_resume_step");

      $display("[TB] single requester");
      for (int k = 0; k < 40; k++)
         applyStimulus(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, ~P0, "single_hold");
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b110111, "single_drop");

      $display("[TB] round robin");
      applyStimulus(1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0, 6'b111110, "rr_reset_a");
      applyStimulus(1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0, 6'b111110, "rr_reset_b");
      for (int k = 0; k < 44; k++)
         applyStimulus(1'b1, 4'b1011, 1'b1, rr_g[k / 8], 1'b1, rr_l[k / 8], "rr_seq");

      $display("[TB] reset mid-grant");
      applyStimulus(1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0, 6'b111110, "mid_reset");
      applyStimulus(1'b1, 4'b1001, 1'b1, 4'b0001, 1'b1, ~P0, "post_reset_grant");

      $display("[TB] early release to another requester");
      applyStimulus(1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, ~P0, "hold_t1");
      applyStimulus(1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, ~P0, "hold_t2");
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, ~P1, "switch_slice");
      applyStimulus(1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, ~P0, "slice_expiry");
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b111110, "back_idle");

      applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 6'b000000, "drain");
      repeat (3) @(posedge clk);
      #4;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL queue_drain: got %0d entries expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
